// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: request sizes, memory
// transfer types, FSM states and the store lane-merge helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_BYTE    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  // Memory type codes deliberately reuse the request size codes.
  localparam logic [1:0] MEM_TYPE_WORD = 2'b00;
  localparam logic [1:0] MEM_TYPE_HALF = 2'b01;
  localparam logic [1:0] MEM_TYPE_BYTE = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  // Replace one half/byte lane of a read word with right-aligned store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input size_e       size,
                                             input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    if (size == SIZE_HALF) begin
      if (lane[1]) merged[31:16] = wdata[15:0];
      else         merged[15:0]  = wdata[15:0];
    end else if (size == SIZE_BYTE) begin
      case (lane)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data path: picks the addressed lane out of a memory word and
// sign- or zero-extends it to 32 bits.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  always_comb begin
    data = '0;
    case (size)
      SIZE_WORD: data = word;
      SIZE_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SIZE_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit in front of a word-wide data memory, with
// read-modify-write for sub-word stores at nonzero lane offsets.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit RMW_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [12:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_ena_o,
  output logic        mem_wena_o,
  output logic [10:0] mem_addr_o,
  output logic [1:0]  mem_type_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  state_e      state;
  logic        we_q;
  size_e       size_q;
  logic        unsigned_q;
  logic [12:0] addr_q;
  logic [31:0] wdata_q;
  logic        ena_q;
  logic        wena_q;
  logic [1:0]  type_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  size_e       req_size;
  logic        misaligned;
  logic        needs_rmw;
  logic        req_err;
  logic [31:0] load_data;

  assign req_size = size_e'(req_size_i);

  always_comb begin
    case (req_size)
      SIZE_WORD: misaligned = (req_addr_i[1:0] != 2'b00);
      SIZE_HALF: misaligned = req_addr_i[0];
      SIZE_BYTE: misaligned = 1'b0;
      default:   misaligned = 1'b1;
    endcase
    needs_rmw = req_we_i && (req_size != SIZE_WORD) && (req_addr_i[1:0] != 2'b00);
    req_err   = misaligned || (needs_rmw && !RMW_EN);
  end

  load_extend u_load_extend (
    .word        (mem_rdata_i),
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .data        (load_data)
  );

  // Memory strobes and response fields are one-cycle pulses by default.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SIZE_WORD;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ena_q        <= 1'b0;
      wena_q       <= 1'b0;
      type_q       <= MEM_TYPE_WORD;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      ena_q        <= 1'b0;
      wena_q       <= 1'b0;
      type_q       <= MEM_TYPE_WORD;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q       <= req_we_i;
            size_q     <= req_size;
            unsigned_q <= req_unsigned_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            if (req_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we_i || needs_rmw) begin
              state <= RD;
              ena_q <= 1'b1;
            end else begin
              state       <= WR;
              ena_q       <= 1'b1;
              wena_q      <= 1'b1;
              type_q      <= req_size_i;
              mem_wdata_q <= req_wdata_i;
            end
          end
        end
        RD: state <= RDW;
        RDW: begin
          if (we_q) begin
            state       <= WR;
            ena_q       <= 1'b1;
            wena_q      <= 1'b1;
            mem_wdata_q <= merge_lane(mem_rdata_i, wdata_q, size_q, addr_q[1:0]);
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
          end
        end
        WR: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  // Reset blocks the strobes immediately, even mid-cycle of a write.
  assign mem_ena_o    = ena_q & ~rst_i;
  assign mem_wena_o   = wena_q & ~rst_i;
  assign mem_addr_o   = addr_q[12:2];
  assign mem_type_o   = type_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit against a behavioural
// word memory with one-cycle read latency.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [12:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_ena_o;
  logic        mem_wena_o;
  logic [10:0] mem_addr_o;
  logic [1:0]  mem_type_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.RMW_EN(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_ena_o      (mem_ena_o),
    .mem_wena_o     (mem_wena_o),
    .mem_addr_o     (mem_addr_o),
    .mem_type_o     (mem_type_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Behavioural data memory plus a log of enables and the most recent write.
  logic [31:0] mem [0:2047];
  int          ena_count = 0;
  int          wr_count  = 0;
  int          rst_wr_count = 0;
  logic [10:0] last_wr_addr;
  logic [1:0]  last_wr_type;
  logic [31:0] last_wr_data;

  always @(posedge clk_i) begin
    if (mem_ena_o) begin
      ena_count <= ena_count + 1;
      if (mem_wena_o) begin
        wr_count     <= wr_count + 1;
        if (rst_i) rst_wr_count <= rst_wr_count + 1;
        last_wr_addr <= mem_addr_o;
        last_wr_type <= mem_type_o;
        last_wr_data <= mem_wdata_o;
        case (mem_type_o)
          2'b00:   mem[mem_addr_o]       <= mem_wdata_o;
          2'b01:   mem[mem_addr_o][15:0] <= mem_wdata_o[15:0];
          default: mem[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
        endcase
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ena;
    logic        exp_wr;
    logic [1:0]  exp_wtype;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [21];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request, waits for its response and reports latency in
  // cycles after the accept edge plus the number of enable cycles used.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [12:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int enas, output logic seen);
    int waited = 0;
    int e0;
    @(negedge clk_i);
    while (!req_ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    e0             = ena_count;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 12) begin
      @(negedge clk_i);
      lat++;
    end
    seen  = resp_valid_o;
    rdata = resp_rdata_o;
    err   = resp_err_o;
    enas  = ena_count - e0;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    logic        seen;
    int          lat;
    int          enas;
    int          w0;
    int          stray;

    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem_rdata_i = '0;

    //            we    size   uns   addr     wdata         rdata         err  lat ena wr   type   wdata
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 13'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 1'b1, 2'b00, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 13'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 13'h010, 32'h11223344, 32'h00000000, 1'b0, 2, 1, 1'b1, 2'b00, 32'h11223344};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 13'h014, 32'h000080FF, 32'h00000000, 1'b0, 2, 1, 1'b1, 2'b00, 32'h000080FF};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 13'h013, 32'h0,        32'h00000011, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 2'b10, 1'b1, 13'h012, 32'h0,        32'h00000022, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 13'h012, 32'h0,        32'h00001122, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 13'h014, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 13'h014, 32'h0,        32'h000080FF, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 13'h014, 32'h0,        32'hFFFF80FF, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 13'h011, 32'h000000AB, 32'h00000000, 1'b0, 4, 2, 1'b1, 2'b00, 32'h1122AB44};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 13'h010, 32'h0,        32'h1122AB44, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[12] = '{1'b1, 2'b01, 1'b0, 13'h012, 32'h0000CAFE, 32'h00000000, 1'b0, 4, 2, 1'b1, 2'b00, 32'hCAFEAB44};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 13'h010, 32'h00005555, 32'h00000000, 1'b0, 2, 1, 1'b1, 2'b01, 32'h00005555};
    vecs[14] = '{1'b0, 2'b00, 1'b0, 13'h010, 32'h0,        32'hCAFE5555, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[15] = '{1'b1, 2'b10, 1'b0, 13'h010, 32'h00000077, 32'h00000000, 1'b0, 2, 1, 1'b1, 2'b10, 32'h00000077};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 13'h010, 32'h0,        32'hCAFE5577, 1'b0, 3, 1, 1'b0, 2'b00, 32'h0};
    vecs[17] = '{1'b0, 2'b00, 1'b0, 13'h012, 32'h0,        32'h00000000, 1'b1, 1, 0, 1'b0, 2'b00, 32'h0};
    vecs[18] = '{1'b0, 2'b11, 1'b0, 13'h010, 32'h0,        32'h00000000, 1'b1, 1, 0, 1'b0, 2'b00, 32'h0};
    vecs[19] = '{1'b0, 2'b01, 1'b1, 13'h011, 32'h0,        32'h00000000, 1'b1, 1, 0, 1'b0, 2'b00, 32'h0};
    vecs[20] = '{1'b1, 2'b00, 1'b0, 13'h011, 32'h12345678, 32'h00000000, 1'b1, 1, 0, 1'b0, 2'b00, 32'h0};

    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    repeat (3) @(negedge clk_i);

    checkOutput("reset_ready",      {31'd0, req_ready_o},  32'd1);
    checkOutput("reset_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("reset_resp_err",   {31'd0, resp_err_o},   32'd0);
    checkOutput("reset_resp_rdata", resp_rdata_o,          32'd0);
    checkOutput("reset_mem_ena",    {31'd0, mem_ena_o},    32'd0);
    checkOutput("reset_mem_addr",   {21'd0, mem_addr_o},   32'd0);
    checkOutput("reset_mem_wdata",  mem_wdata_o,           32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    rdata, err, lat, enas, seen);
      checkOutput($sformatf("v%0d_resp_seen", i), {31'd0, seen}, 32'd1);
      checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_ena_cycles", i), enas, vecs[i].exp_ena);
      if (vecs[i].exp_wr) begin
        checkOutput($sformatf("v%0d_wr_addr", i), {21'd0, last_wr_addr}, {21'd0, vecs[i].addr[12:2]});
        checkOutput($sformatf("v%0d_wr_type", i), {30'd0, last_wr_type}, {30'd0, vecs[i].exp_wtype});
        checkOutput($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_wdata);
      end
    end

    // Back-to-back: next request held from the RESP cycle is taken in the following IDLE cycle.
    applyStimulus(1'b0, 2'b00, 1'b0, 13'h014, 32'h0, rdata, err, lat, enas, seen);
    checkOutput("b2b_first_rdata", rdata, 32'h000080FF);
    req_valid_i    = 1'b1;
    req_we_i       = 1'b0;
    req_size_i     = 2'b10;
    req_unsigned_i = 1'b1;
    req_addr_i     = 13'h015;
    @(negedge clk_i);
    checkOutput("b2b_idle_ready",      {31'd0, req_ready_o},  32'd1);
    checkOutput("b2b_idle_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("b2b_busy_ready", {31'd0, req_ready_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    checkOutput("b2b_second_valid", {31'd0, resp_valid_o}, 32'd1);
    checkOutput("b2b_second_rdata", resp_rdata_o, 32'h00000080);

    // Reset pulsed during the WR cycle of a word store must suppress the write.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'b00;
    req_addr_i  = 13'h018;
    req_wdata_i = 32'h12345678;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("rstwr_wena_before", {31'd0, mem_wena_o}, 32'd1);
    w0    = wr_count;
    rst_i = 1'b1;
    #1;
    checkOutput("rstwr_wena_in_reset", {31'd0, mem_wena_o}, 32'd0);
    checkOutput("rstwr_ena_in_reset",  {31'd0, mem_ena_o},  32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rstwr_ready_after", {31'd0, req_ready_o}, 32'd1);
    stray = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (resp_valid_o || mem_ena_o) stray++;
    end
    checkOutput("rstwr_no_activity", stray, 0);
    checkOutput("rstwr_no_write", wr_count - w0, 0);
    checkOutput("rstwr_write_in_reset", rst_wr_count, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 13'h018, 32'h0, rdata, err, lat, enas, seen);
    checkOutput("rstwr_word_unchanged", rdata, 32'h00000000);
    checkOutput("rstwr_reload_seen", {31'd0, seen}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
